// File: rtl/reflet_mem_arbiter_pkg.sv
// Shared definitions for the Reflet memory arbiter: FSM state encoding,
// round-robin pointer reset value and a small helper for the pick logic.
// Optional feature macro: REFLET_ARB_ROUND_ROBIN_EN (see reflet_arb_pick).
package reflet_mem_arbiter_pkg;

    // Two-bit FSM encoding shared with the other Reflet blocks
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_ISSUE   = 2'b01,
        ARB_CAPTURE = 2'b10,
        ARB_DONE    = 2'b11
    } arb_state_t;

    // Pointer holds the id of the last granted master; starting at 1 gives
    // master 0 (the CPU) first priority after reset
    localparam logic RR_POINTER_RESET = 1'b1;

    // Id of the master that was not granted last time
    function automatic logic other_master(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/reflet_arb_pick.sv
// Combinational winner selection between the two bus masters.
// Default build: fixed priority, master 0 wins every tie.
// With REFLET_ARB_ROUND_ROBIN_EN defined: a tie goes to the master that was
// not granted last; a lone requester always wins.
module reflet_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_id,
    output logic grant_valid,
    output logic grant_id
);
    import reflet_mem_arbiter_pkg::*;

    // Choose the winning master from the current requests
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = 1'b0;
`ifdef REFLET_ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            grant_id = other_master(last_id);
        end else begin
            grant_id = req1;
        end
`else
        grant_id = ~req0 & req1;
`endif
    end

`ifndef REFLET_ARB_ROUND_ROBIN_EN
    // Pointer is meaningless under fixed priority
    logic unused_last_id;
    assign unused_last_id = last_id;
`endif

endmodule

// File: rtl/reflet_mem_arbiter.sv
// Two-master arbiter in front of the single Reflet RAM port. Serialises
// single-word reads and writes through an IDLE/ISSUE/CAPTURE/DONE FSM and
// returns a one-cycle ack to the owning master.
// Optional feature macro: REFLET_ARB_ROUND_ROBIN_EN enables round-robin
// arbitration and builds the pointer register; otherwise master 0 has
// fixed priority.
module reflet_mem_arbiter #(
    parameter int wordsize = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic [wordsize-1:0] addr0,
    input  logic [wordsize-1:0] addr1,
    input  logic [wordsize-1:0] wdata0,
    input  logic [wordsize-1:0] wdata1,
    output logic [wordsize-1:0] rdata,
    output logic                ack0,
    output logic                ack1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                busy,
    output logic [wordsize-1:0] mem_addr,
    output logic [wordsize-1:0] mem_data_out,
    input  logic [wordsize-1:0] mem_data_in,
    output logic                mem_write_en
);
    import reflet_mem_arbiter_pkg::*;

    arb_state_t          state;
    arb_state_t          next_state;
    logic                lat_we;
    logic                lat_owner;
    logic [wordsize-1:0] lat_addr;
    logic [wordsize-1:0] lat_wdata;
    logic [wordsize-1:0] rdata_q;
    logic                grant_valid;
    logic                grant_id;
    logic                last_id;
    logic                take_grant;

    assign take_grant = enable && (state == ARB_IDLE) && grant_valid;

    reflet_arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_id     (last_id),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

`ifdef REFLET_ARB_ROUND_ROBIN_EN
    logic rr_last;

    // Remember which master was granted most recently
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_last <= RR_POINTER_RESET;
        end else if (take_grant) begin
            rr_last <= grant_id;
        end
    end

    assign last_id = rr_last;
`else
    assign last_id = RR_POINTER_RESET;
`endif

    // State register; enable low freezes the FSM in place
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ARB_IDLE;
        end else if (enable) begin
            state <= next_state;
        end
    end

    // Next-state logic: reads pass through CAPTURE, writes skip it
    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE:    next_state = grant_valid ? ARB_ISSUE : ARB_IDLE;
            ARB_ISSUE:   next_state = lat_we ? ARB_DONE : ARB_CAPTURE;
            ARB_CAPTURE: next_state = ARB_DONE;
            ARB_DONE:    next_state = ARB_IDLE;
            default:     next_state = ARB_IDLE;
        endcase
    end

    // Latch the winning master's transaction at grant time
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_owner <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (take_grant) begin
            lat_owner <= grant_id;
            lat_we    <= grant_id ? we1 : we0;
            lat_addr  <= grant_id ? addr1 : addr0;
            lat_wdata <= grant_id ? wdata1 : wdata0;
        end
    end

    // Capture registered RAM read data; held until the next read
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (enable && (state == ARB_CAPTURE)) begin
            rdata_q <= mem_data_in;
        end
    end

    // Output decode from the current state and latched owner
    always_comb begin
        rdata        = rdata_q;
        mem_addr     = lat_addr;
        mem_data_out = lat_wdata;
        mem_write_en = 1'b0;
        busy         = (state != ARB_IDLE);
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        if (state != ARB_IDLE) begin
            gnt0 = ~lat_owner;
            gnt1 = lat_owner;
        end
        case (state)
            ARB_ISSUE: mem_write_en = lat_we;
            ARB_DONE: begin
                ack0 = ~lat_owner;
                ack1 = lat_owner;
            end
            default: begin
                mem_write_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_reflet_mem_arbiter.sv
// Self-checking bench for reflet_mem_arbiter: directed steps with a
// scoreboard queue of expected completions and a registered RAM model.
module tb_reflet_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic [15:0] rdata;
    logic        ack0, ack1, gnt0, gnt1, busy;
    logic [15:0] mem_addr, mem_data_out, mem_data_in;
    logic        mem_write_en;

    typedef struct {
        logic        id;
        logic        we;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          compared = 0;
    int          mismatched = 0;
    int          ack_pulses0 = 0;
    int          ack_pulses1 = 0;
    logic        prev_ack0 = 1'b0;
    logic        prev_ack1 = 1'b0;
    logic [15:0] ram [0:255];

    reflet_mem_arbiter #(.wordsize(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .rdata        (rdata),
        .ack0         (ack0),
        .ack1         (ack1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered RAM, gated by enable like the real part
    always @(posedge clk) begin
        if (enable) begin
            if (mem_write_en) ram[mem_addr[7:0]] <= mem_data_out;
            mem_data_in <= ram[mem_addr[7:0]];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic id, input logic req, input logic we,
                                 input logic [15:0] addr, input logic [15:0] wdata);
        if (id) begin
            req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
        end
    endtask

    task automatic pushExpect(input logic id, input logic we, input logic [15:0] data);
        exp_t e;
        e.id = id; e.we = we; e.data = data;
        sb.push_back(e);
    endtask

    // Advance one cycle and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (ack0 && !prev_ack0) ack_pulses0++;
        if (ack1 && !prev_ack1) ack_pulses1++;
        prev_ack0 = ack0;
        prev_ack1 = ack1;
    endtask

    // Pop the oldest expected completion and compare it with the live ack
    task automatic scoreAck();
        exp_t e;
        compared++;
        assert (sb.size() != 0) else begin
            mismatched++;
            $error("[TB] FAIL sb_unexpected_ack observed=%0d expected=nonzero queue", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("sb_ack_owner", {30'd0, ack1, ack0}, e.id ? 32'd2 : 32'd1);
            if (!e.we) checkOutput("sb_rdata", {16'd0, rdata}, {16'd0, e.data});
        end
    endtask

    // Bounded wait for any ack, then score it
    task automatic waitAck(input int budget);
        int n = 0;
        while (!(ack0 || ack1) && n < budget) begin
            tick();
            n++;
        end
        compared++;
        assert (ack0 || ack1) else begin
            mismatched++;
            $error("[TB] FAIL ack_timeout observed=none expected=ack within %0d cycles", budget);
        end
        if (ack0 || ack1) scoreAck();
    endtask

    initial begin
        int base;
        int exp_id;
        reset = 1'b0; enable = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        tick(); tick();

        $display("[TB] reset state");
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_gnt", {gnt1, gnt0}, 0);
        checkOutput("rst_ack", {ack1, ack0}, 0);
        checkOutput("rst_we", mem_write_en, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_wdata", mem_data_out, 0);
        checkOutput("rst_rdata", rdata, 0);
        reset = 1'b1;
        tick();
        checkOutput("idle_no_req", busy, 0);

        $display("[TB] single CPU write");
        applyStimulus(0, 1, 1, 16'h0040, 16'hBEEF);
        pushExpect(0, 1, 16'h0);
        checkOutput("w_c0_we", mem_write_en, 0);
        tick();
        checkOutput("w_c1_we", mem_write_en, 1);
        checkOutput("w_c1_addr", mem_addr, 16'h0040);
        checkOutput("w_c1_data", mem_data_out, 16'hBEEF);
        checkOutput("w_c1_gnt", {gnt1, gnt0}, 2'b01);
        tick();
        checkOutput("w_c2_we", mem_write_en, 0);
        checkOutput("w_c2_ack0", ack0, 1);
        scoreAck();
        applyStimulus(0, 0, 0, 16'h0, 16'h0);
        tick();
        checkOutput("w_c3_busy", busy, 0);
        checkOutput("w_c3_rdata_kept", rdata, 0);

        $display("[TB] read-back by master 1");
        base = ack_pulses0;
        applyStimulus(1, 1, 0, 16'h0040, 16'h0);
        pushExpect(1, 0, 16'hBEEF);
        tick();
        checkOutput("r_c1_gnt", {gnt1, gnt0}, 2'b10);
        checkOutput("r_c1_we", mem_write_en, 0);
        checkOutput("r_c1_addr", mem_addr, 16'h0040);
        tick();
        checkOutput("r_c2_ack", {ack1, ack0}, 0);
        tick();
        checkOutput("r_c3_ack1", ack1, 1);
        scoreAck();
        applyStimulus(1, 0, 0, 16'h0, 16'h0);
        tick();
        checkOutput("r_c4_busy", busy, 0);
        checkOutput("r_no_ack0", ack_pulses0 - base, 0);

        $display("[TB] simultaneous continuous requests from reset");
        reset = 1'b0;
        applyStimulus(0, 1, 1, 16'h0010, 16'h1111);
        applyStimulus(1, 1, 1, 16'h0020, 16'h2222);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef REFLET_ARB_ROUND_ROBIN_EN
            exp_id = k % 2;
`else
            exp_id = 0;
`endif
            pushExpect(exp_id[0], 1, 16'h0);
            tick();
            waitAck(8);
        end
        applyStimulus(0, 0, 0, 16'h0, 16'h0);
        applyStimulus(1, 0, 0, 16'h0, 16'h0);
        tick();
        checkOutput("tie_end_busy", busy, 0);
        checkOutput("tie_m0_written", ram[8'h10], 16'h1111);

        $display("[TB] reset during CAPTURE");
        base = ack_pulses0;
        applyStimulus(0, 1, 0, 16'h0010, 16'h0);
        tick();
        tick();
        checkOutput("rr_capture_busy", busy, 1);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 16'h0, 16'h0);
        tick();
        checkOutput("rr_busy", busy, 0);
        checkOutput("rr_gnt", {gnt1, gnt0}, 0);
        checkOutput("rr_ack", {ack1, ack0}, 0);
        checkOutput("rr_we", mem_write_en, 0);
        checkOutput("rr_addr", mem_addr, 0);
        checkOutput("rr_rdata", rdata, 0);
        reset = 1'b1;
        tick();
        checkOutput("rr_no_ack", ack_pulses0 - base, 0);
        applyStimulus(0, 1, 0, 16'h0010, 16'h0);
        pushExpect(0, 0, 16'h1111);
        tick();
        tick();
        checkOutput("rr2_c2_ack", ack0, 0);
        tick();
        checkOutput("rr2_c3_ack0", ack0, 1);
        scoreAck();
        applyStimulus(0, 0, 0, 16'h0, 16'h0);
        tick();
        checkOutput("rr2_c4_busy", busy, 0);

        $display("[TB] enable stall in DONE");
        base = ack_pulses1;
        applyStimulus(1, 1, 1, 16'h0030, 16'h3333);
        pushExpect(1, 1, 16'h0);
        tick();
        tick();
        checkOutput("st_ack1", ack1, 1);
        scoreAck();
        enable = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            checkOutput("st_ack1_held", ack1, 1);
        end
        enable = 1'b1;
        applyStimulus(1, 0, 0, 16'h0, 16'h0);
        tick();
        checkOutput("st_release_ack", ack1, 0);
        checkOutput("st_release_busy", busy, 0);
        checkOutput("st_single_pulse", ack_pulses1 - base, 1);
        tick();
        checkOutput("st_no_repeat", busy, 0);

        $display("[TB] losing master changes address");
        applyStimulus(0, 1, 1, 16'h0050, 16'h5555);
        applyStimulus(1, 1, 0, 16'h0060, 16'h0);
        pushExpect(0, 1, 16'h0);
        tick();
        checkOutput("lc_c1_gnt", {gnt1, gnt0}, 2'b01);
        checkOutput("lc_c1_addr", mem_addr, 16'h0050);
        checkOutput("lc_c1_data", mem_data_out, 16'h5555);
        checkOutput("lc_c1_we", mem_write_en, 1);
        applyStimulus(1, 1, 0, 16'h0030, 16'h0);
        tick();
        checkOutput("lc_c2_ack0", ack0, 1);
        scoreAck();
        applyStimulus(0, 0, 0, 16'h0, 16'h0);
        pushExpect(1, 0, 16'h3333);
        tick();
        checkOutput("lc_idle_busy", busy, 0);
        tick();
        checkOutput("lc_m1_gnt", {gnt1, gnt0}, 2'b10);
        checkOutput("lc_m1_addr", mem_addr, 16'h0030);
        tick();
        tick();
        checkOutput("lc_m1_ack", ack1, 1);
        scoreAck();
        applyStimulus(1, 0, 0, 16'h0, 16'h0);
        tick();
        checkOutput("lc_m0_write_landed", ram[8'h50], 16'h5555);
        checkOutput("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time limit so the bench always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
